// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: FSM states, load
// funct3 encodings and default datapath widths.
package wb_pkg;

  localparam int XLEN_DEFAULT  = 64;
  localparam int RADDR_DEFAULT = 5;

  typedef enum logic [0:0] {
    IDLE,
    WAIT_LOAD
  } wb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_stage_load_extend.sv
// Combinational load data extraction: picks the addressed byte/half/word out
// of an aligned 64-bit word and sign- or zero-extends it.
module load_extend
  import wb_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  funct3,
  input  logic [2:0]  addr_lo,
  output logic [63:0] value,
  output logic        misalign
);

  logic [2:0]  offset;
  logic [63:0] shifted;

  // Offset is aligned down to the access size; dropped low bits flag misalign.
  always_comb begin
    offset   = addr_lo;
    misalign = 1'b0;
    case (funct3)
      F3_LB, F3_LBU: begin
        offset   = addr_lo;
        misalign = 1'b0;
      end
      F3_LH, F3_LHU: begin
        offset   = {addr_lo[2:1], 1'b0};
        misalign = addr_lo[0];
      end
      F3_LW, F3_LWU: begin
        offset   = {addr_lo[2], 2'b00};
        misalign = |addr_lo[1:0];
      end
      default: begin
        offset   = 3'b000;
        misalign = |addr_lo;
      end
    endcase

    shifted = data >> {offset, 3'b000};

    case (funct3)
      F3_LB:   value = {{56{shifted[7]}},  shifted[7:0]};
      F3_LH:   value = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   value = {{32{shifted[31]}}, shifted[31:0]};
      F3_LBU:  value = {56'd0, shifted[7:0]};
      F3_LHU:  value = {48'd0, shifted[15:0]};
      F3_LWU:  value = {32'd0, shifted[31:0]};
      default: value = shifted;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage driving the register-file write port. ALU results retire
// one cycle after acceptance; loads wait for the memory response.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int RADDR = RADDR_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [RADDR-1:0] ex_rd,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_funct3,
  input  logic [2:0]       ex_addr_lo,
  input  logic             mem_resp_valid,
  input  logic [XLEN-1:0]  mem_resp_data,
  output logic             write_sig,
  output logic [RADDR-1:0] write_reg,
  output logic [XLEN-1:0]  write_val,
  output logic             pend_valid,
  output logic [RADDR-1:0] pend_rd,
  output logic             misalign
);

  wb_state_t        state, state_next;
  logic             alu_accept, load_accept, load_done;
  logic [RADDR-1:0] cap_rd;
  logic [2:0]       cap_funct3;
  logic [2:0]       cap_addr_lo;
  logic [XLEN-1:0]  ext_value;
  logic             ext_misalign;

  load_extend u_load_extend (
    .data     (mem_resp_data),
    .funct3   (cap_funct3),
    .addr_lo  (cap_addr_lo),
    .value    (ext_value),
    .misalign (ext_misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    alu_accept  = 1'b0;
    load_accept = 1'b0;
    load_done   = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          alu_accept  = !ex_is_load;
          load_accept = ex_is_load;
          if (ex_is_load) state_next = WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        if (mem_resp_valid) begin
          load_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ex_ready   = (state == IDLE);
  assign pend_valid = (state == WAIT_LOAD);
  assign pend_rd    = pend_valid ? cap_rd : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_rd      <= '0;
      cap_funct3  <= '0;
      cap_addr_lo <= '0;
    end else if (load_accept) begin
      cap_rd      <= ex_rd;
      cap_funct3  <= ex_funct3;
      cap_addr_lo <= ex_addr_lo;
    end
  end

  // Writes to x0 are suppressed at the enable but still update index/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_sig <= 1'b0;
      write_reg <= '0;
      write_val <= '0;
      misalign  <= 1'b0;
    end else begin
      write_sig <= 1'b0;
      misalign  <= 1'b0;
      if (alu_accept) begin
        write_sig <= (ex_rd != '0);
        write_reg <= ex_rd;
        write_val <= ex_result;
      end else if (load_done) begin
        write_sig <= (cap_rd != '0);
        write_reg <= cap_rd;
        write_val <= ext_value;
        misalign  <= ext_misalign;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [63:0] ex_result;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic [2:0]  ex_addr_lo;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        write_sig;
  logic [4:0]  write_reg;
  logic [63:0] write_val;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        misalign;

  int checks;
  int failures;

  // Reference model state: an outstanding load and the expected next write.
  bit          m_pending;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [2:0]  m_addr;

  wb_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_rd          (ex_rd),
    .ex_result      (ex_result),
    .ex_is_load     (ex_is_load),
    .ex_funct3      (ex_funct3),
    .ex_addr_lo     (ex_addr_lo),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .write_sig      (write_sig),
    .write_reg      (write_reg),
    .write_val      (write_val),
    .pend_valid     (pend_valid),
    .pend_rd        (pend_rd),
    .misalign       (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Load result from plain arithmetic: access size in bytes, aligned offset, mask, extend.
  function automatic logic [63:0] refLoad(input logic [63:0] data, input logic [2:0] f3,
                                          input logic [2:0] addr, output bit mis);
    int nbytes;
    int a;
    int off;
    bit sgn;
    logic [63:0] v;
    logic [63:0] mask;
    case (f3)
      3'd0, 3'd4: nbytes = 1;
      3'd1, 3'd5: nbytes = 2;
      3'd2, 3'd6: nbytes = 4;
      default:    nbytes = 8;
    endcase
    sgn = (f3 < 3'd4);
    a   = int'(addr);
    off = (a / nbytes) * nbytes;
    mis = (a % nbytes) != 0;
    v   = data >> (off * 8);
    if (nbytes < 8) begin
      mask = (64'd1 << (nbytes * 8)) - 64'd1;
      v = v & mask;
      if (sgn && v[nbytes*8-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Drives one cycle of inputs at the negedge, checks pre-edge handshake
  // outputs, advances the model, then checks registered outputs after the edge.
  task automatic applyStimulus(input bit v, input logic [4:0] rd, input logic [63:0] res,
                               input bit ld, input logic [2:0] f3, input logic [2:0] addr,
                               input bit rv, input logic [63:0] rdata);
    bit          e_sig;
    logic [4:0]  e_reg;
    logic [63:0] e_val;
    bit          e_mis;
    ex_valid       = v;
    ex_rd          = rd;
    ex_result      = res;
    ex_is_load     = ld;
    ex_funct3      = f3;
    ex_addr_lo     = addr;
    mem_resp_valid = rv;
    mem_resp_data  = rdata;
    #1;
    checkOutput("ex_ready", 64'(ex_ready), 64'(!m_pending));
    checkOutput("pend_valid", 64'(pend_valid), 64'(m_pending));
    if (m_pending) checkOutput("pend_rd", 64'(pend_rd), 64'(m_rd));

    e_sig = 0; e_reg = '0; e_val = '0; e_mis = 0;
    if (!m_pending && v) begin
      if (!ld) begin
        e_sig = (rd != 0);
        e_reg = rd;
        e_val = res;
      end else begin
        m_pending = 1;
        m_rd = rd; m_f3 = f3; m_addr = addr;
      end
    end else if (m_pending && rv) begin
      e_sig = (m_rd != 0);
      e_reg = m_rd;
      e_val = refLoad(rdata, m_f3, m_addr, e_mis);
      m_pending = 0;
    end

    @(posedge clk);
    #1;
    checkOutput("write_sig", 64'(write_sig), 64'(e_sig));
    if (e_sig) begin
      checkOutput("write_reg", 64'(write_reg), 64'(e_reg));
      checkOutput("write_val", write_val, e_val);
    end
    checkOutput("misalign", 64'(misalign), 64'(e_mis));
    checkOutput("pend_valid_post", 64'(pend_valid), 64'(m_pending));
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(0, 5'd0, 64'd0, 0, 3'd0, 3'd0, 0, 64'd0);
  endtask

  task automatic doReset();
    reset          = 1'b1;
    ex_valid       = 1'b0;
    mem_resp_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_pending = 0;
    checkOutput("rst_write_sig", 64'(write_sig), 64'd0);
    checkOutput("rst_write_reg", 64'(write_reg), 64'd0);
    checkOutput("rst_write_val", write_val, 64'd0);
    checkOutput("rst_pend_valid", 64'(pend_valid), 64'd0);
    checkOutput("rst_pend_rd", 64'(pend_rd), 64'd0);
    checkOutput("rst_misalign", 64'(misalign), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit          hv;
    logic [4:0]  hrd;
    logic [63:0] hres;
    bit          hld;
    logic [2:0]  hf3;
    logic [2:0]  haddr;
    bit          accepted;

    checks = 0; failures = 0;
    m_pending = 0; m_rd = '0; m_f3 = '0; m_addr = '0;
    reset = 1'b1;
    ex_valid = 0; ex_rd = '0; ex_result = '0; ex_is_load = 0;
    ex_funct3 = '0; ex_addr_lo = '0; mem_resp_valid = 0; mem_resp_data = '0;
    @(negedge clk);
    doReset();

    $display("[TB] single ALU write");
    applyStimulus(1, 5'd5, 64'h1234, 0, 3'd0, 3'd0, 0, 64'd0);
    idleCycle();

    $display("[TB] back-to-back ALU writes");
    applyStimulus(1, 5'd1, 64'h11, 0, 3'd0, 3'd0, 0, 64'd0);
    applyStimulus(1, 5'd2, 64'h22, 0, 3'd0, 3'd0, 0, 64'd0);
    applyStimulus(1, 5'd3, 64'h33, 0, 3'd0, 3'd0, 0, 64'd0);
    idleCycle();

    $display("[TB] LB load with delayed response");
    applyStimulus(1, 5'd7, 64'd0, 1, 3'b000, 3'd3, 0, 64'd0);
    idleCycle(); idleCycle(); idleCycle();
    applyStimulus(0, 5'd0, 64'd0, 0, 3'd0, 3'd0, 1, 64'h00000000_80000000);
    checkOutput("lb_literal", write_val, 64'hFFFFFFFF_FFFFFF80);
    idleCycle();

    $display("[TB] LWU zero-extension after stray response");
    applyStimulus(0, 5'd0, 64'd0, 0, 3'd0, 3'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(1, 5'd9, 64'd0, 1, 3'b110, 3'd4, 0, 64'd0);
    idleCycle();
    applyStimulus(0, 5'd0, 64'd0, 0, 3'd0, 3'd0, 1, 64'hDEADBEEF_00000000);
    checkOutput("lwu_literal", write_val, 64'h00000000_DEADBEEF);

    $display("[TB] load to x0 and misaligned LH");
    applyStimulus(1, 5'd0, 64'd0, 1, 3'b011, 3'd0, 0, 64'd0);
    idleCycle();
    applyStimulus(0, 5'd0, 64'd0, 0, 3'd0, 3'd0, 1, 64'h0123_4567_89AB_CDEF);
    applyStimulus(1, 5'd10, 64'd0, 1, 3'b001, 3'd1, 0, 64'd0);
    applyStimulus(0, 5'd0, 64'd0, 0, 3'd0, 3'd0, 1, 64'h11223344_55668001);
    checkOutput("lh_mis_literal", 64'(misalign), 64'd1);
    checkOutput("lh_val_literal", write_val, 64'hFFFFFFFF_FFFF8001);
    idleCycle();

    $display("[TB] reset during outstanding load");
    applyStimulus(1, 5'd12, 64'd0, 1, 3'b010, 3'd0, 0, 64'd0);
    idleCycle();
    doReset();
    applyStimulus(0, 5'd0, 64'd0, 0, 3'd0, 3'd0, 1, 64'hAAAA_BBBB_CCCC_DDDD);
    idleCycle();

    $display("[TB] randomized traffic");
    hv = 0; hrd = '0; hres = '0; hld = 0; hf3 = '0; haddr = '0;
    for (int i = 0; i < 600; i++) begin
      if (!hv) begin
        hv    = ($urandom_range(0, 3) != 0);
        hrd   = 5'($urandom_range(0, 31));
        hres  = {$urandom, $urandom};
        hld   = ($urandom_range(0, 2) == 0);
        hf3   = 3'($urandom_range(0, 7));
        haddr = 3'($urandom_range(0, 7));
      end
      accepted = hv && !m_pending;
      applyStimulus(hv, hrd, hres, hld, hf3, haddr,
                    ($urandom_range(0, 2) == 0), {$urandom, $urandom});
      if (accepted) hv = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage that sits directly upstream of the register file and drives its write port (write_sig/write_reg/write_val).
- Accepts retiring results from execute.
- ALU results are written one cycle after acceptance.
- Loads are held until the memory response arrives, then byte-extracted and sign- or zero-extended.
- Exposes the pending load destination so decode can stall on load-use hazards.

Parameters:
XLEN, 64, datapath width (register and memory-response width).
RADDR, 5, register index width.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ex_valid  in  1  execute presents a retiring instruction
ex_ready  out  1  stage can accept this cycle
ex_rd  in  RADDR  destination register
ex_result  in  XLEN  ALU result (ignored for loads)
ex_is_load  in  1  instruction is a load
ex_funct3  in  3  load width/sign code
ex_addr_lo  in  3  load byte offset within the 64-bit word
mem_resp_valid  in  1  load data returned (single-cycle pulse)
mem_resp_data  in  XLEN  aligned 64-bit word containing load data
write_sig  out  1  register-file write enable
write_reg  out  RADDR  register-file write index
write_val  out  XLEN  register-file write data
pend_valid  out  1  a load is outstanding
pend_rd  out  RADDR  destination of the outstanding load
misalign  out  1  one-cycle pulse: load offset not aligned to its size

Behaviour:
- Reset: state=IDLE; write_sig=0, write_reg=0, write_val=0, pend_valid=0, pend_rd=0, misalign=0. Reset mid-load abandons the load; a later mem_resp_valid is ignored.
- Outputs write_sig/write_reg/write_val/misalign are registered. write_sig is asserted for exactly one cycle per write.
- States:
  - IDLE: ex_ready=1.
  - WAIT_LOAD: ex_ready=0.
- Accept = ex_valid && ex_ready.
- IDLE, accept, !ex_is_load:
  - Next cycle: write_sig=1, write_reg=ex_rd, write_val=ex_result.
  - Stay in IDLE. Back-to-back ALU writes sustain 1 per cycle.
- IDLE, accept, ex_is_load:
  - Capture rd, funct3 and addr_lo; go to WAIT_LOAD.
  - pend_valid=1 and pend_rd=rd from the next cycle.
  - No write is issued for the load on this cycle.
- WAIT_LOAD, mem_resp_valid:
  - Next cycle: write_sig=1, write_reg=captured rd, write_val=extend(mem_resp_data); return to IDLE.
  - pend_valid drops in the same cycle write_sig rises.
  - Latency: write appears 1 cycle after the response.
- mem_resp_valid while IDLE: ignored.
- ex_valid while WAIT_LOAD: not accepted. Upstream holds ex_valid and its fields stable until accepted.
- rd=0: write_sig stays 0; a load to x0 still waits for its response.
- Extraction uses the offset aligned down to the access size: byte=any offset, half=addr_lo[2:1], word=addr_lo[2], double=0.
- funct3 codes:
  - 000 LB: sign-extend 8 bits.
  - 001 LH: sign-extend 16 bits.
  - 010 LW: sign-extend 32 bits.
  - 011 LD: full 64 bits.
  - 100 LBU / 101 LHU / 110 LWU: zero-extend.
  - 111: treated as LD.
- misalign pulses alongside the write when the offset bits below the access size are nonzero, e.g. LH with addr_lo[0]=1. The write still occurs using the aligned-down data.

Decomposition:
- Package wb_pkg holds:
  - state enum {IDLE, WAIT_LOAD};
  - funct3 localparams F3_LB..F3_LWU;
  - XLEN/RADDR defaults.
- One combinational sub-module, load_extend:
  - inputs: data[63:0], funct3, addr_lo;
  - outputs: value[63:0], misalign.
- The FSM and output registers stay in wb_stage.

Test Plan:
1. ALU: ex_valid, rd=5, result=0x1234, cycle N -> cycle N+1: write_sig=1, write_reg=5, write_val=0x1234; cycle N+2: write_sig=0.
2. Back-to-back ALU: rd=1,2,3 on 3 consecutive cycles -> 3 consecutive write pulses in order. ex_ready stays 1 throughout.
3. LB load: rd=7, funct3=000, addr_lo=3; response 0x00000000_80000000 arriving 4 cycles later.
   - pend_valid=1, pend_rd=7 and ex_ready=0 during the wait.
   - Cycle after response: write_val=0xFFFFFFFF_FFFFFF80.
   - Then pend_valid=0.
4. Zero-extension: LWU, addr_lo=4, data=0xDEADBEEF_00000000 -> write_val=0x00000000_DEADBEEF. A stray mem_resp_valid issued beforehand in IDLE has no effect.
5. Corner cases:
   - Load to x0 -> no write_sig, yet FSM returns to IDLE after the response.
   - LH with addr_lo=1 -> misalign pulse; data taken from bytes 0-1.
6. Reset mid-load: assert reset in WAIT_LOAD, then send mem_resp_valid -> no write_sig, pend_valid=0, ex_ready=1.
